// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: glyph constants and BCD decode helper shared by the scan driver
package seg7_scan_driver_pkg;
    localparam int BCD_W = 4;
    typedef logic [6:0] glyph_t;
    // active-high {g,f,e,d,c,b,a}
    localparam glyph_t SEG_OFF  = 7'h00;
    localparam glyph_t SEG_DASH = 7'h40;
    localparam glyph_t SEG_0 = 7'h3F;
    localparam glyph_t SEG_1 = 7'h06;
    localparam glyph_t SEG_2 = 7'h5B;
    localparam glyph_t SEG_3 = 7'h4F;
    localparam glyph_t SEG_4 = 7'h66;
    localparam glyph_t SEG_5 = 7'h6D;
    localparam glyph_t SEG_6 = 7'h7D;
    localparam glyph_t SEG_7 = 7'h07;
    localparam glyph_t SEG_8 = 7'h7F;
    localparam glyph_t SEG_9 = 7'h6F;

    function automatic glyph_t bcd_glyph(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit/control inputs and segment/anode pins of the scan driver
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 4);
    import seg7_scan_driver_pkg::*;
    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        load;
    logic                        blank_lz;
    logic                        blink_en;
    glyph_t                      seg;
    logic                        dp;
    logic [NUM_DIGITS-1:0]       an;
    logic                        frame_done;
    modport master (output digits_in, dp_in, load, blank_lz, blink_en, input seg, dp, an, frame_done);
    modport slave (input digits_in, dp_in, load, blank_lz, blink_en, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver_decoder.sv
// seg7_scan_driver_decoder: BCD digit plus blank flag to active-high glyph
module seg7_scan_driver_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             blank_i,
    output glyph_t           glyph_o
);
    assign glyph_o = blank_i ? SEG_OFF : bcd_glyph(digit_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes packed BCD digits onto one 7-segment bus with per-digit anodes,
// leading-zero blanking, blinking and frame-aligned (tear-free) display updates
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 250,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BW  = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW  = BCD_W * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_q, pend_d, disp_q, disp_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  blink_off_q, blink_off_d;
    glyph_t                seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick, wrap, dead, blink_last;
    logic [NUM_DIGITS-1:0] lz;
    logic [BCD_W-1:0]      cur;
    logic                  cur_dp, cur_lz;
    glyph_t                glyph;

    // a digit is blanked when it and every more-significant digit is zero; digit0 always shows
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
        if (g == 0) begin : g_lsd
            assign lz[g] = 1'b0;
        end else begin : g_msd
            assign lz[g] = bus.blank_lz && ~|disp_q[DW-1:BCD_W*g];
        end
    end

    always_comb begin
        cur = '0;
        cur_dp = 1'b0;
        cur_lz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur = disp_q[BCD_W*k +: BCD_W];
                cur_dp = disp_dp_q[k];
                cur_lz = lz[k];
            end
        end
    end

    seg7_scan_driver_decoder u_dec (
        .digit_i (cur),
        .blank_i (cur_lz),
        .glyph_o (glyph)
    );

    always_comb begin
        tick = presc_q == PW'(DIV - 1);
        wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
        dead = presc_q < PW'(DEAD_CYC);
        blink_last = bcnt_q == BW'(BLINK_FRAMES - 1);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
        pend_d = bus.load ? bus.digits_in : pend_q;
        pend_dp_d = bus.load ? bus.dp_in : pend_dp_q;
        // display samples the pending value held before this edge, so a coincident load waits a frame
        disp_d = wrap ? pend_q : disp_q;
        disp_dp_d = wrap ? pend_dp_q : disp_dp_q;
        bcnt_d = !wrap ? bcnt_q : blink_last ? '0 : bcnt_q + 1'b1;
        blink_off_d = blink_off_q ^ (wrap && blink_last);
        seg_d = (dead ? SEG_OFF : glyph) ^ {7{SEG_ACT_LOW}};
        dp_d = (!dead && cur_dp) ^ SEG_ACT_LOW;
        an_d = ((!dead && !(bus.blink_en && blink_off_q) && (!cur_lz || cur_dp))
               ? NUM_DIGITS'(1) << idx_q : '0) ^ {NUM_DIGITS{AN_ACT_LOW}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q <= '0;
            pend_q <= '0;
            pend_dp_q <= '0;
            disp_q <= '0;
            disp_dp_q <= '0;
            bcnt_q <= '0;
            blink_off_q <= 1'b0;
            seg_q <= {7{SEG_ACT_LOW}};
            dp_q <= SEG_ACT_LOW;
            an_q <= {NUM_DIGITS{AN_ACT_LOW}};
        end else begin
            presc_q <= presc_d;
            idx_q <= idx_d;
            pend_q <= pend_d;
            pend_dp_q <= pend_dp_d;
            disp_q <= disp_d;
            disp_dp_q <= disp_dp_d;
            bcnt_q <= bcnt_d;
            blink_off_q <= blink_off_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
            an_q <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp = dp_q;
    assign bus.an = an_q;
    assign bus.frame_done = wrap;
endmodule
